// File: rtl/apb_hex_display_mux_if.sv
// APB bus bundle for apb_hex_display_mux.
// Signals keep their APB names so existing connections map one-to-one.
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE : master -> slave
//   PRDATA/PREADY/PSLVERR            : slave -> master
interface apb_hex_display_mux_if #(
    parameter int unsigned ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [31:0]           PWDATA;
    logic                  PWRITE;
    logic                  PSEL;
    logic                  PENABLE;
    logic [31:0]           PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_hex_display_mux.sv
// APB-controlled multiplexed 7-segment display driver for NUM_DIGITS digits.
// Per-digit enable and decimal-point masks, programmable refresh prescaler,
// and one blank cycle at every digit change to suppress ghosting.
// Optional macro HEX_PWM_EN adds a DUTY register (0x14) for brightness PWM.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   apb    : APB slave (PADDR[4:2] decoded, zero wait states)
//   seg_o  : segments a..g, active-low, [0]=a
//   dp_o   : decimal point, active-low
//   an_o   : digit anodes, active-low, bit i = digit i
module apb_hex_display_mux #(
    parameter int unsigned NUM_DIGITS     = 8,
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter logic [15:0] PRESCALE_RST   = 16'd9999
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    apb_hex_display_mux_if.slave  apb,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [NUM_DIGITS-1:0] an_o
);

    typedef enum logic {S_BLANK, S_SHOW} state_e;

    localparam int unsigned   IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    // Nibbles of non-existent digits are never stored, so they read back as 0.
    localparam logic [63:0]   DATA_MASK = (NUM_DIGITS >= 16) ? '1
                                          : ((64'd1 << (4 * NUM_DIGITS)) - 64'd1);

    logic [63:0]           data_q;
    logic                  en_q;
    logic [15:0]           dig_en_q, dpmask_q, prescale_q;
    logic [15:0]           pre_cnt_q, pre_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    state_e                state_q, state_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
`ifdef HEX_PWM_EN
    logic [7:0]            duty_q, pwm_cnt_q;
`endif

    logic [2:0]  reg_sel;
    logic        mapped, wr_en, tick;
    logic [31:0] rdata;
    logic [3:0]  idx4, nib;
    logic        unused_addr;

    assign reg_sel     = apb.PADDR[4:2];
    assign unused_addr = ^{apb.PADDR[APB_ADDR_WIDTH-1:5], apb.PADDR[1:0]};

    function automatic logic [6:0] hex_font(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Address decode and combinational read mux.
    always_comb begin
        mapped = 1'b1;
        rdata  = '0;
        case (reg_sel)
            3'd0: rdata = data_q[31:0];
            3'd1: rdata = data_q[63:32];
            3'd2: rdata = {dig_en_q, 15'd0, en_q};
            3'd3: rdata = {16'd0, dpmask_q};
            3'd4: rdata = {16'd0, prescale_q};
`ifdef HEX_PWM_EN
            3'd5: rdata = {24'd0, duty_q};
`endif
            default: mapped = 1'b0;
        endcase
    end

    assign apb.PRDATA  = rdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = apb.PSEL & apb.PENABLE & ~mapped;
    assign wr_en       = apb.PSEL & apb.PENABLE & apb.PWRITE & mapped;

    // Register file.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q     <= '0;
            en_q       <= 1'b0;
            dig_en_q   <= '0;
            dpmask_q   <= '0;
            prescale_q <= PRESCALE_RST;
`ifdef HEX_PWM_EN
            duty_q     <= 8'hFF;
`endif
        end else if (wr_en) begin
            case (reg_sel)
                3'd0: data_q[31:0]  <= apb.PWDATA & DATA_MASK[31:0];
                3'd1: data_q[63:32] <= apb.PWDATA & DATA_MASK[63:32];
                3'd2: begin
                    en_q     <= apb.PWDATA[0];
                    dig_en_q <= apb.PWDATA[31:16];
                end
                3'd3: dpmask_q   <= apb.PWDATA[15:0];
                3'd4: prescale_q <= apb.PWDATA[15:0];
`ifdef HEX_PWM_EN
                3'd5: duty_q     <= apb.PWDATA[7:0];
`endif
                default: ;
            endcase
        end
    end

    assign tick = en_q && (pre_cnt_q == prescale_q);

    // Prescaler, scan index and BLANK/SHOW sequencing.
    // A tick in BLANK still advances idx but keeps the FSM in BLANK.
    always_comb begin
        pre_cnt_d = pre_cnt_q + 16'd1;
        idx_d     = idx_q;
        state_d   = state_q;
        if (!en_q) begin
            pre_cnt_d = '0;
            idx_d     = '0;
            state_d   = S_BLANK;
        end else begin
            if (tick) begin
                pre_cnt_d = '0;
                idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end
            if (wr_en && reg_sel == 3'd4) begin
                pre_cnt_d = '0;
            end
            case (state_q)
                S_BLANK: state_d = tick ? S_BLANK : S_SHOW;
                S_SHOW:  state_d = tick ? S_BLANK : S_SHOW;
                default: state_d = S_BLANK;
            endcase
        end
    end

    assign idx4 = 4'(idx_q);
    assign nib  = data_q[{idx4, 2'b00} +: 4];

    // Next output values; a disabled digit keeps its slot with its anode off.
    always_comb begin
        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (en_q && state_q == S_SHOW) begin
            seg_d = ~hex_font(nib);
            dp_d  = ~dpmask_q[idx4];
`ifdef HEX_PWM_EN
            if (pwm_cnt_q < duty_q) begin
                an_d[idx_q] = ~dig_en_q[idx4];
            end
`else
            an_d[idx_q] = ~dig_en_q[idx4];
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_cnt_q <= '0;
            idx_q     <= '0;
            state_q   <= S_BLANK;
            an_q      <= '1;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
`ifdef HEX_PWM_EN
            pwm_cnt_q <= '0;
`endif
        end else begin
            pre_cnt_q <= pre_cnt_d;
            idx_q     <= idx_d;
            state_q   <= state_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
`ifdef HEX_PWM_EN
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
`endif
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;
    assign dp_o  = dp_q;

endmodule

// File: tb/tb_apb_hex_display_mux.sv
// Scoreboard bench for apb_hex_display_mux (NUM_DIGITS=8).
// Stimulus pushes expectations right after a clock edge; the monitor pops
// and compares everything queued on the following falling edge.
module tb_apb_hex_display_mux;

    localparam int K_RD = 0, K_ERR = 1, K_AN = 2, K_SEG = 3, K_DP = 4, K_RDY = 5, K_CNT = 6;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
        logic [31:0] act;
    } item_t;

    logic       clk;
    logic       rst_i;
    logic [6:0] seg_o;
    logic       dp_o;
    logic [7:0] an_o;

    item_t sbq[$];
    item_t it;
    int    n_cmp = 0;
    int    n_err = 0;

    // Font as given, active-high before inversion.
    logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [7:0] AN_ALL8 [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] AN_D0D2 [8] = '{8'hFE, 8'hFF, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    apb_hex_display_mux_if #(.ADDR_WIDTH(12)) bus ();

    apb_hex_display_mux #(
        .NUM_DIGITS     (8),
        .APB_ADDR_WIDTH (12),
        .PRESCALE_RST   (16'd9999)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .apb   (bus.slave),
        .seg_o (seg_o),
        .dp_o  (dp_o),
        .an_o  (an_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void expect_val(input string nm, input int k, input logic [31:0] e,
                                       input logic [31:0] a = '0);
        item_t x;
        x.name = nm; x.kind = k; x.exp = e; x.act = a;
        sbq.push_back(x);
    endfunction

    function automatic void expect_disp(input string nm, input logic [7:0] an,
                                        input logic [6:0] seg, input logic dp);
        expect_val({nm, ".an"},  K_AN,  {24'd0, an});
        expect_val({nm, ".seg"}, K_SEG, {25'd0, seg});
        expect_val({nm, ".dp"},  K_DP,  {31'd0, dp});
    endfunction

    // Monitor: compare every queued expectation against the DUT at the falling edge.
    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            logic [31:0] act;
            it = sbq.pop_front();
            case (it.kind)
                K_RD:    act = bus.PRDATA;
                K_ERR:   act = {31'd0, bus.PSLVERR};
                K_AN:    act = {24'd0, an_o};
                K_SEG:   act = {25'd0, seg_o};
                K_DP:    act = {31'd0, dp_o};
                K_RDY:   act = {31'd0, bus.PREADY};
                default: act = it.act;
            endcase
            n_cmp++;
            if (act !== it.exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h at %0t", it.name, act, it.exp, $time);
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, input logic err,
                             input string nm);
        bus.PADDR = a; bus.PWDATA = d; bus.PWRITE = 1'b1; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        expect_val({nm, ".slverr"}, K_ERR, {31'd0, err});
        @(posedge clk); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, input logic [31:0] d, input logic err,
                            input string nm);
        bus.PADDR = a; bus.PWRITE = 1'b0; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        expect_val({nm, ".prdata"}, K_RD, d);
        expect_val({nm, ".slverr"}, K_ERR, {31'd0, err});
        @(posedge clk); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.PADDR = '0; bus.PWDATA = '0; bus.PWRITE = 1'b0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        rst_i = 1'b1;

        // 1: reset state
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        expect_disp("rst", 8'hFF, 7'h7F, 1'b1);
        expect_val("rst.pready", K_RDY, 32'd1);
        step();
        apb_read(12'h010, 32'd9999, 1'b0, "rst.prescale");
        apb_read(12'h008, 32'd0, 1'b0, "rst.ctrl");
        expect_disp("rst2", 8'hFF, 7'h7F, 1'b1);

        // 2: all digits, PRESCALE=3 -> 1 blank + 3 SHOW cycles per slot
        apb_write(12'h010, 32'd3, 1'b0, "t2.prescale");
        apb_write(12'h000, 32'h7654_3210, 1'b0, "t2.data0");
        apb_write(12'h008, 32'h00FF_0001, 1'b0, "t2.ctrl");
        for (int c = 1; c <= 36; c++) begin
            int p, d;
            step();
            p = (c - 1) % 4;
            d = ((c - 1) / 4) % 8;
            if (p == 0) expect_disp($sformatf("t2.c%0d", c), 8'hFF, 7'h7F, 1'b1);
            else        expect_disp($sformatf("t2.c%0d", c), AN_ALL8[d], ~FONT[d], 1'b1);
        end

        // 3: digits 0 and 2 enabled, dp on digit 2
        apb_write(12'h008, 32'h0000_0000, 1'b0, "t3.ctrl_off");
        apb_write(12'h00C, 32'h0000_0004, 1'b0, "t3.dpmask");
        apb_write(12'h008, 32'h0005_0001, 1'b0, "t3.ctrl");
        for (int c = 1; c <= 32; c++) begin
            int p, d;
            step();
            p = (c - 1) % 4;
            d = ((c - 1) / 4) % 8;
            if (p == 0) expect_disp($sformatf("t3.c%0d", c), 8'hFF, 7'h7F, 1'b1);
            else        expect_disp($sformatf("t3.c%0d", c), AN_D0D2[d], ~FONT[d], (d == 2) ? 1'b0 : 1'b1);
        end

        // 4: PRESCALE=0 mid-count -> display goes dark and stays dark
        repeat (2) step();
        apb_write(12'h010, 32'd0, 1'b0, "t4.prescale");
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c >= 2) expect_disp($sformatf("t4.c%0d", c), 8'hFF, 7'h7F, 1'b1);
        end
        apb_read(12'h010, 32'd0, 1'b0, "t4.prescale_rd");

        // 5: unmapped accesses
        apb_read(12'h018, 32'd0, 1'b1, "t5.rd18");
        apb_write(12'h018, 32'hFFFF_FFFF, 1'b1, "t5.wr18");
        apb_write(12'h004, 32'hFFFF_FFFF, 1'b0, "t5.wr_data1");
        apb_read(12'h000, 32'h7654_3210, 1'b0, "t5.data0");
        apb_read(12'h004, 32'd0, 1'b0, "t5.data1");
        apb_read(12'h008, 32'h0005_0001, 1'b0, "t5.ctrl");
        apb_read(12'h00C, 32'h0000_0004, 1'b0, "t5.dpmask");
        apb_read(12'h010, 32'd0, 1'b0, "t5.prescale");
`ifdef HEX_PWM_EN
        apb_read(12'h014, 32'h0000_00FF, 1'b0, "t5.duty_rst");
        apb_write(12'h014, 32'h0000_0040, 1'b0, "t5.wr14");
        apb_read(12'h014, 32'h0000_0040, 1'b0, "t5.duty");

        // 6: DUTY=0x40 -> anode on for 64 of any 256 consecutive SHOW cycles; DUTY=0 -> dark
        apb_write(12'h008, 32'h0000_0000, 1'b0, "t6.ctrl_off");
        apb_write(12'h010, 32'd600, 1'b0, "t6.prescale");
        apb_write(12'h008, 32'h0001_0001, 1'b0, "t6.ctrl");
        begin
            int on_cnt;
            on_cnt = 0;
            for (int c = 1; c <= 257; c++) begin
                @(negedge clk);
                if (c >= 2 && an_o == 8'hFE) on_cnt++;
                @(posedge clk); #1;
            end
            expect_val("t6.on_count", K_CNT, 32'd64, on_cnt);
        end
        apb_write(12'h014, 32'h0000_0000, 1'b0, "t6.duty0");
        for (int c = 1; c <= 40; c++) begin
            step();
            if (c >= 2) expect_val($sformatf("t6.dark.c%0d", c), K_AN, 32'h0000_00FF);
        end
`else
        apb_write(12'h014, 32'h0000_0040, 1'b1, "t5.wr14");
        apb_read(12'h014, 32'd0, 1'b1, "t5.rd14");
`endif

        // 7: reset pulse during SHOW
        apb_write(12'h008, 32'h0000_0000, 1'b0, "t7.ctrl_off");
        apb_write(12'h010, 32'd3, 1'b0, "t7.prescale");
        apb_write(12'h008, 32'h00FF_0001, 1'b0, "t7.ctrl");
        repeat (3) step();
        expect_val("t7.pre_show", K_AN, 32'h0000_00FE);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        expect_disp("t7.after", 8'hFF, 7'h7F, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            step();
            expect_disp($sformatf("t7.c%0d", c), 8'hFF, 7'h7F, 1'b1);
        end
        apb_read(12'h010, 32'd9999, 1'b0, "t7.prescale");
        apb_read(12'h008, 32'd0, 1'b0, "t7.ctrl");
        apb_read(12'h000, 32'd0, 1'b0, "t7.data0");
        apb_read(12'h00C, 32'd0, 1'b0, "t7.dpmask");

        @(posedge clk);
        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
